// File: rtl/rps_stream_pkg.sv
// -----------------------------------------------------------------------------
// rps_stream_pkg
//   Shared definitions for the valid/ready stream blocks.
//
//   STREAM_DATA_W : default stream payload width
//   gen_state_t   : frame generator FSM states
//   stream_beat_t : one stream beat {last, data}, used wherever a beat is
//                   carried as a single value (queues, skid buffers, models)
// -----------------------------------------------------------------------------
package rps_stream_pkg;

    localparam int STREAM_DATA_W = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    typedef struct packed {
        logic                     last;
        logic [STREAM_DATA_W-1:0] data;
    } stream_beat_t;

endpackage

// File: rtl/stream_frame_gen.sv
// -----------------------------------------------------------------------------
// stream_frame_gen
//   Configurable frame-stream transmitter. A run sends cfg_frames frames of
//   cfg_beats beats each; every beat of frame n carries n (zero-extended) and
//   the final beat of each frame carries last. cfg_gap idle cycles follow
//   each frame's last beat (except the final frame).
//
// Ports
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-high reset
//   start             in   one-cycle pulse; latches cfg_* and begins a run (IDLE only)
//   cfg_beats         in   beats per frame (0 is treated as 1)
//   cfg_frames        in   frames per run (0 = empty run, done only)
//   cfg_gap           in   idle cycles after each non-final frame
//   io_out_valid      out  beat valid
//   io_out_ready      in   downstream ready
//   io_out_bits_last  out  final beat of a frame
//   io_out_bits_data  out  zero-extended frame index
//   busy              out  run in progress
//   done              out  one-cycle pulse when a run completes
//   frames_sent       out  frames completed in the current or last run
//
// All outputs come straight from registers; valid never looks at ready.
// -----------------------------------------------------------------------------
module stream_frame_gen
    import rps_stream_pkg::*;
#(
    parameter int DATA_W   = STREAM_DATA_W,
    parameter int BEATS_W  = 16,
    parameter int FRAMES_W = 32,
    parameter int GAP_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [BEATS_W-1:0]  cfg_beats,
    input  logic [FRAMES_W-1:0] cfg_frames,
    input  logic [GAP_W-1:0]    cfg_gap,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic                io_out_bits_last,
    output logic [DATA_W-1:0]   io_out_bits_data,
    output logic                busy,
    output logic                done,
    output logic [FRAMES_W-1:0] frames_sent
);

    // -------------------------------------------------------------------------
    // State and run configuration
    // -------------------------------------------------------------------------
    gen_state_t          state_q;
    logic [BEATS_W-1:0]  beats_q;      // effective beats per frame (never 0)
    logic [FRAMES_W-1:0] frames_q;
    logic [GAP_W-1:0]    gap_q;
    logic [BEATS_W-1:0]  beat_idx_q;
    logic [FRAMES_W-1:0] frame_idx_q;  // also the completed-frame count
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;

    // -------------------------------------------------------------------------
    // Next-value helpers
    // -------------------------------------------------------------------------
    logic [BEATS_W-1:0]  cfg_beats_d;
    logic [BEATS_W-1:0]  beat_idx_d;
    logic [FRAMES_W-1:0] frame_idx_d;
    logic                hs_d;
    logic                final_frame_d;
    logic                gap_over_d;

    assign cfg_beats_d   = (cfg_beats == '0) ? BEATS_W'(1) : cfg_beats;
    assign beat_idx_d    = beat_idx_q + BEATS_W'(1);
    assign frame_idx_d   = frame_idx_q + FRAMES_W'(1);
    assign hs_d          = valid_q && io_out_ready;
    assign final_frame_d = (frame_idx_d == frames_q);
    assign gap_over_d    = (gap_cnt_q == gap_q - GAP_W'(1));

    // -------------------------------------------------------------------------
    // FSM and counters
    // -------------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so that all of them see
    // the pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beats_q     <= BEATS_W'(1);
            frames_q    <= '0;
            gap_q       <= '0;
            beat_idx_q  <= '0;
            frame_idx_q <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        beats_q     <= cfg_beats_d;
                        frames_q    <= cfg_frames;
                        gap_q       <= cfg_gap;
                        beat_idx_q  <= '0;
                        frame_idx_q <= '0;
                        gap_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                        if (cfg_frames != '0) begin
                            state_q <= SEND;
                            valid_q <= 1'b1;
                            last_q  <= (cfg_beats_d == BEATS_W'(1));
                        end else begin
                            // Empty run: busy and done share the single DONE cycle.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    // valid, data and last only move on a handshake, which
                    // keeps the beat stable while ready is low.
                    if (hs_d) begin
                        if (last_q) begin
                            beat_idx_q  <= '0;
                            frame_idx_q <= frame_idx_d;
                            if (final_frame_d) begin
                                state_q <= DONE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (gap_q != '0) begin
                                state_q   <= GAP;
                                valid_q   <= 1'b0;
                                last_q    <= 1'b0;
                                gap_cnt_q <= '0;
                            end else begin
                                // Back-to-back frame: first beat of the next
                                // frame is presented with no bubble.
                                last_q <= (beats_q == BEATS_W'(1));
                            end
                        end else begin
                            beat_idx_q <= beat_idx_d;
                            last_q     <= (beat_idx_d == beats_q - BEATS_W'(1));
                        end
                    end
                end

                GAP: begin
                    // GAP is entered with valid already low, so leaving on the
                    // gap_q-th cycle yields exactly gap_q idle cycles.
                    if (gap_over_d) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                        last_q  <= (beats_q == BEATS_W'(1));
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all direct register taps)
    // -------------------------------------------------------------------------
    assign io_out_valid     = valid_q;
    assign io_out_bits_last = last_q;
    assign io_out_bits_data = DATA_W'(frame_idx_q);
    assign busy             = busy_q;
    assign done             = done_q;
    assign frames_sent      = frame_idx_q;

endmodule

// File: tb/tb_stream_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_stream_frame_gen
//   Scoreboard bench: each run pushes its expected beats into a queue before
//   start; a monitor pops and compares on every handshake and also watches
//   stream-hold rules, intra-frame bubbles and inter-frame gap length.
// -----------------------------------------------------------------------------
module tb_stream_frame_gen;
    import rps_stream_pkg::*;

    localparam int DATA_W   = STREAM_DATA_W;
    localparam int BEATS_W  = 16;
    localparam int FRAMES_W = 32;
    localparam int GAP_W    = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic [BEATS_W-1:0]  cfg_beats;
    logic [FRAMES_W-1:0] cfg_frames;
    logic [GAP_W-1:0]    cfg_gap;
    logic                io_out_valid;
    logic                io_out_ready;
    logic                io_out_bits_last;
    logic [DATA_W-1:0]   io_out_bits_data;
    logic                busy;
    logic                done;
    logic [FRAMES_W-1:0] frames_sent;

    stream_frame_gen #(
        .DATA_W  (DATA_W),
        .BEATS_W (BEATS_W),
        .FRAMES_W(FRAMES_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .cfg_beats       (cfg_beats),
        .cfg_frames      (cfg_frames),
        .cfg_gap         (cfg_gap),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_bits_last(io_out_bits_last),
        .io_out_bits_data(io_out_bits_data),
        .busy            (busy),
        .done            (done),
        .frames_sent     (frames_sent)
    );

    always #5 clock = ~clock;

    int unsigned  cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    stream_beat_t exp_q[$];
    int           pass_cnt    = 0;
    int           total_cnt   = 0;
    int           exp_gap     = 0;
    int           hs_cnt      = 0;
    int unsigned  last_hs_cyc = 0;
    bit           ready_toggle = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Ready driver: constant 1, or alternating 1,0,1,0 when ready_toggle is set.
    initial begin
        io_out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            io_out_ready = ready_toggle ? ~io_out_ready : 1'b1;
        end
    end

    // Monitor: compares every handshake against the scoreboard.
    initial begin : monitor
        stream_beat_t      exp;
        bit                await_first = 1'b0;
        bit                in_frame    = 1'b0;
        bit                stall       = 1'b0;
        int                low_cnt     = 0;
        logic              prev_last   = 1'b0;
        logic [DATA_W-1:0] prev_data   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                await_first = 1'b0;
                in_frame    = 1'b0;
                stall       = 1'b0;
            end else begin
                if (done) await_first = 1'b0;
                if (stall) begin
                    check("hold_valid", DATA_W'(io_out_valid), DATA_W'(1));
                    check("hold_data", io_out_bits_data, prev_data);
                    check("hold_last", DATA_W'(io_out_bits_last), DATA_W'(prev_last));
                end
                if (in_frame) check("no_bubble", DATA_W'(io_out_valid), DATA_W'(1));
                if (await_first) begin
                    if (io_out_valid) begin
                        check("gap_len", DATA_W'(low_cnt), DATA_W'(exp_gap));
                        await_first = 1'b0;
                    end else begin
                        low_cnt++;
                    end
                end
                stall     = io_out_valid && !io_out_ready;
                prev_data = io_out_bits_data;
                prev_last = io_out_bits_last;
                if (io_out_valid && io_out_ready) begin
                    hs_cnt++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", DATA_W'(exp_q.size()), DATA_W'(1));
                    end else begin
                        exp = exp_q.pop_front();
                        check("beat_data", io_out_bits_data, exp.data);
                        check("beat_last", DATA_W'(io_out_bits_last), DATA_W'(exp.last));
                        if (exp.last) begin
                            await_first = 1'b1;
                            low_cnt     = 0;
                            in_frame    = 1'b0;
                        end else begin
                            in_frame = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Expected beats of one run: frame f repeated max(beats,1) times.
    task automatic push_run(input int beats, input int frames);
        stream_beat_t e;
        int b;
        b = (beats == 0) ? 1 : beats;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < b; i++) begin
                e      = '0;
                e.data = DATA_W'(f);
                e.last = (i == b - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_run(input int beats, input int frames, input int gap);
        push_run(beats, frames);
        @(posedge clock);
        #1;
        cfg_beats  = BEATS_W'(beats);
        cfg_frames = FRAMES_W'(frames);
        cfg_gap    = GAP_W'(gap);
        exp_gap    = gap;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_start", DATA_W'(busy), DATA_W'(1));
        check("valid_after_start", DATA_W'(io_out_valid), DATA_W'(frames != 0));
        check("sent_cleared", DATA_W'(frames_sent), DATA_W'(0));
    endtask

    task automatic wait_done(input int exp_frames, input bit chk_latency);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 3000);
        check("done_seen", DATA_W'(done), DATA_W'(1));
        check("frames_sent", DATA_W'(frames_sent), DATA_W'(exp_frames));
        check("busy_at_done", DATA_W'(busy), DATA_W'(exp_frames == 0));
        check("queue_drained", DATA_W'(exp_q.size()), DATA_W'(0));
        if (exp_frames == 0) check("empty_done_cycle", DATA_W'(n), DATA_W'(1));
        if (chk_latency) check("done_latency", DATA_W'(cyc - last_hs_cyc), DATA_W'(1));
        @(negedge clock);
        check("done_one_cycle", DATA_W'(done), DATA_W'(0));
        check("busy_after_done", DATA_W'(busy), DATA_W'(0));
        check("valid_after_done", DATA_W'(io_out_valid), DATA_W'(0));
        repeat (2) @(posedge clock);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        cfg_beats  = '0;
        cfg_frames = '0;
        cfg_gap    = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid", DATA_W'(io_out_valid), DATA_W'(0));
        check("rst_last", DATA_W'(io_out_bits_last), DATA_W'(0));
        check("rst_data", io_out_bits_data, DATA_W'(0));
        check("rst_busy", DATA_W'(busy), DATA_W'(0));
        check("rst_done", DATA_W'(done), DATA_W'(0));
        check("rst_frames_sent", DATA_W'(frames_sent), DATA_W'(0));

        // 17 frames x 4 beats, back to back, ready always high.
        start_run(4, 17, 0);
        wait_done(17, 1'b1);

        // Same run with ready alternating.
        ready_toggle = 1'b1;
        start_run(4, 17, 0);
        wait_done(17, 1'b1);
        ready_toggle = 1'b0;
        repeat (2) @(posedge clock);

        // Single-beat frames with a 2-cycle gap.
        start_run(1, 3, 2);
        wait_done(3, 1'b1);

        // Empty run.
        start_run(4, 0, 0);
        wait_done(0, 1'b0);

        // start during a run with a different config is ignored.
        start_run(3, 4, 1);
        repeat (5) @(posedge clock);
        #1;
        cfg_beats  = BEATS_W'(2);
        cfg_frames = FRAMES_W'(1);
        cfg_gap    = GAP_W'(0);
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(4, 1'b1);

        // Reset after beat 2 of frame 5, then a fresh short run.
        base = hs_cnt;
        start_run(4, 8, 0);
        n = 0;
        while (hs_cnt < base + 18 && n < 500) begin
            @(posedge clock);
            n++;
        end
        check("reach_reset_point", DATA_W'(hs_cnt - base), DATA_W'(18));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", DATA_W'(io_out_valid), DATA_W'(0));
        check("midrst_busy", DATA_W'(busy), DATA_W'(0));
        check("midrst_frames_sent", DATA_W'(frames_sent), DATA_W'(0));
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        start_run(4, 2, 0);
        wait_done(2, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stream_frame_gen.md
# stream_frame_gen

Synthesizable frame-stream transmitter that drives a 512-bit valid/ready stream with `last` framing, the same shape the Accelerator consumes on `io_in`. It replaces hand-written per-beat stimulus with a configurable generator: N frames of M beats each, data = frame index, optional idle gap between frames. It sits in front of the Accelerator in on-chip self-test and loopback builds, and feeds it in simulation benches.

## Interface
- `DATA_W`, 512, stream data width
- `BEATS_W`, 16, width of the beats-per-frame config and beat counter
- `FRAMES_W`, 32, width of the frame-count config and frame counter
- `GAP_W`, 8, width of the inter-frame gap config
- `clock`  in  1  single clock; everything is rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches config and begins a run when idle
- `cfg_beats`  in  BEATS_W  beats per frame; 0 treated as 1
- `cfg_frames`  in  FRAMES_W  frames per run; 0 means an empty run
- `cfg_gap`  in  GAP_W  idle cycles inserted after each frame's last beat
- `io_out_valid`  out  1  beat valid
- `io_out_ready`  in  1  downstream ready
- `io_out_bits_last`  out  1  high on the final beat of each frame
- `io_out_bits_data`  out  DATA_W  zero-extended frame index (0,1,2,...)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at run completion
- `frames_sent`  out  FRAMES_W  completed frames in the current or last run

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: `start`=1 latches `cfg_*`, clears counters and `frames_sent`; goes to SEND if cfg_frames≠0, else DONE. Later changes to `cfg_*` have no effect on a running run.
- SEND: valid=1, data=frame_idx, last=(beat_idx==beats−1). A handshake (valid&&ready) advances beat_idx. On a last-beat handshake: frame_idx++, frames_sent++, beat_idx=0; go to DONE if that was the final frame, else GAP if gap≠0, else stay in SEND.
- GAP: valid=0. Counts `cfg_gap` cycles, then goes to SEND.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Stream rules: once valid rises it stays high, with data and last stable, until the handshake. Valid never depends combinationally on ready.
- Widths: frame_idx has FRAMES_W bits and is zero-extended to DATA_W. Counters do not wrap within a legal run.

## Timing
- Reset values: valid=0, last=0, data=0, busy=0, done=0, frames_sent=0, state=IDLE. Reset takes effect immediately, including mid-frame; the partial frame is abandoned and not resumed.
- All outputs are registered.
- `start` sampled at edge k: busy=1 and valid=1 from cycle k+1.
- With ready held high: one beat per cycle, no bubbles inside a frame or between frames when gap=0.
- gap=G: exactly G valid-low cycles between a last handshake and the next frame's first beat.
- Final last-beat handshake at edge t: busy=0 and done=1 during cycle t+1; IDLE from t+2, and a new `start` is accepted from t+2.
- Empty run (cfg_frames=0): done pulses in cycle k+1, with valid never asserted.

## Structure
- Shared package `rps_stream_pkg`: DATA_W default constant, `gen_state_t` enum {IDLE, SEND, GAP, DONE}, and a `stream_beat_t` struct {last, data} reused by stream blocks.
- Single module; no sub-module is warranted. Counters and the FSM live in one always_ff with async reset.

## Test plan
- beats=4, frames=17, gap=0, ready=1 → 68 consecutive beats; last on beats 4,8,…,68; data 0x0…0x10, each value held for 4 beats; done one cycle after beat 68; frames_sent=17.
- Same config, ready toggling 1,0,1,0… → valid never drops mid-frame; data and last stable during ready=0; beats delivered in the same order as the ready=1 case.
- beats=1, frames=3, gap=2 → every beat has last=1; data 0,1,2; exactly 2 valid-low cycles between beats.
- frames=0 → no valid; done pulses the cycle after start; busy is 1 for that cycle.
- start pulsed mid-run with different cfg_* → ignored; the run completes with the original config.
- reset asserted after beat 2 of frame 5 → valid=0 and busy=0 immediately; frames_sent=0. A new start (beats=4, frames=2) then sends data 0,0,0,0,1,1,1,1 with last on beats 4 and 8.
